// File: rtl/spi_burst_slave_pkg.sv
// Shared definitions for the SPI burst slave: opcodes, frame states,
// transaction kinds, status-byte bit positions and small helpers.
package spi_burst_slave_pkg;

  localparam logic [7:0] OP_WRITE  = 8'h01;
  localparam logic [7:0] OP_READ   = 8'h02;
  localparam logic [7:0] OP_START  = 8'h03;
  localparam logic [7:0] OP_STOP   = 8'h04;
  localparam logic [7:0] OP_STATUS = 8'h05;

  // Status byte layout: {5'b0, start_flag, frame_err, bad_cmd}
  localparam int ST_BAD_CMD   = 0;
  localparam int ST_FRAME_ERR = 1;
  localparam int ST_START     = 2;

  typedef enum logic [2:0] {
    S_CMD, S_LEN, S_ADDR, S_WDATA, S_DUMMY, S_RDATA, S_STAT, S_DONE
  } state_e;

  // Remembered opcode for frames that carry LEN/ADDR.
  typedef enum logic [1:0] {
    K_WRITE, K_READ, K_STATUS
  } kind_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [7:0] status_byte(input logic start, input logic ferr,
                                             input logic bad);
    logic [7:0] s;
    s               = '0;
    s[ST_START]     = start;
    s[ST_FRAME_ERR] = ferr;
    s[ST_BAD_CMD]   = bad;
    return s;
  endfunction

endpackage

// File: rtl/spi_shift_ctr.sv
// MSB-first serial shifter plus bit counter for one frame field.
// Ports:
//   sclk, frame_rst_n  clock / async frame reset (clears shifter and counter)
//   en                 shift this rising edge
//   mosi               serial input bit
//   flen               current field length in bits
//   sr_nxt             shifter contents including the bit being sampled now,
//                      so the owner can capture a field on its completing edge
//   cnt                bits already taken in the current field
//   done               this edge completes the field; counter wraps to 0
module spi_shift_ctr #(
  parameter int W     = 32,
  parameter int CNT_W = 6
) (
  input  logic             sclk,
  input  logic             frame_rst_n,
  input  logic             en,
  input  logic             mosi,
  input  logic [CNT_W-1:0] flen,
  output logic [W-1:0]     sr_nxt,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  logic [W-2:0] sr_q;

  assign sr_nxt = {sr_q, mosi};
  assign done   = en && (cnt == flen - 1'b1);

  always_ff @(posedge sclk or negedge frame_rst_n) begin
    if (!frame_rst_n) begin
      sr_q <= '0;
      cnt  <= '0;
    end else if (en) begin
      sr_q <= sr_nxt[W-2:0];
      cnt  <= done ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_burst_slave.sv
// SPI (mode 0) slave frame engine: decodes CMD/LEN/ADDR frames, runs burst
// writes/reads towards the CPU bridge via toggle handshakes, run control and
// status readback. Single clock domain (sclk).
// Ports:
//   sclk, rstn            SPI clock, async active-low reset
//   cs_n, mosi, miso      SPI pins; miso changes on falling sclk
//   miso_oe               output enable while selected
//   wr_tgl/adr/data/be    write word handoff (toggle flips per word)
//   rd_tgl/adr, rd_data   read word request and returned data
//   start_flag            processor run enable
module spi_burst_slave
  import spi_burst_slave_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 4,
  parameter int DUMMY_CYC = 8
) (
  input  logic                sclk,
  input  logic                rstn,
  input  logic                cs_n,
  input  logic                mosi,
  output logic                miso,
  output logic                miso_oe,
  output logic                wr_tgl,
  output logic [ADDR_W-1:0]   wr_adr,
  output logic [DATA_W-1:0]   wr_data,
  output logic [DATA_W/8-1:0] wr_be,
  output logic                rd_tgl,
  output logic [ADDR_W-1:0]   rd_adr,
  input  logic [DATA_W-1:0]   rd_data,
  output logic                start_flag
);

  localparam int SR_W  = max2(max2(ADDR_W, DATA_W), max2(DUMMY_CYC, 8));
  localparam int CNT_W = $clog2(SR_W + 1);
  localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(DATA_W / 8);

  logic frame_rst_n;
  assign frame_rst_n = rstn & ~cs_n;
  assign miso_oe     = rstn & ~cs_n;

  state_e            state_q, state_d;
  kind_e             kind_q, kind_d;
  logic [LEN_W-1:0]  len_q, wcnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] tx_q;
  logic [CNT_W-1:0]  flen, cnt;
  logic [SR_W-1:0]   sr_nxt;
  logic              fdone, last_word;
  logic              wr_fire, rd_fire, rd_cap, word_done;
  logic              do_start, do_stop, bad_set, stat_end;
  logic              open_q, ferr_set_q, bad_set_q, stat_end_q;
  logic              frame_err, bad_cmd;
  logic [7:0]        stat_byte;
  logic [2:0]        stat_idx;

  assign last_word = (wcnt_q == len_q);

  always_comb begin
    case (state_q)
      S_LEN:            flen = CNT_W'(LEN_W);
      S_ADDR:           flen = CNT_W'(ADDR_W);
      S_WDATA, S_RDATA: flen = CNT_W'(DATA_W);
      S_DUMMY:          flen = CNT_W'(DUMMY_CYC);
      default:          flen = CNT_W'(8);
    endcase
  end

  spi_shift_ctr #(.W(SR_W), .CNT_W(CNT_W)) u_shift (
    .sclk        (sclk),
    .frame_rst_n (frame_rst_n),
    .en          (state_q != S_DONE),
    .mosi        (mosi),
    .flen        (flen),
    .sr_nxt      (sr_nxt),
    .cnt         (cnt),
    .done        (fdone)
  );

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    wr_fire   = 1'b0;
    rd_fire   = 1'b0;
    rd_cap    = 1'b0;
    word_done = 1'b0;
    do_start  = 1'b0;
    do_stop   = 1'b0;
    bad_set   = 1'b0;
    stat_end  = 1'b0;
    case (state_q)
      S_CMD: if (fdone) begin
        case (sr_nxt[7:0])
          OP_WRITE:  begin kind_d = K_WRITE;  state_d = S_LEN; end
          OP_READ:   begin kind_d = K_READ;   state_d = S_LEN; end
          OP_STATUS: begin kind_d = K_STATUS; state_d = S_LEN; end
          OP_START:  begin do_start = 1'b1;   state_d = S_DONE; end
          OP_STOP:   begin do_stop = 1'b1;    state_d = S_DONE; end
          default:   begin bad_set = 1'b1;    state_d = S_DONE; end
        endcase
      end
      S_LEN: if (fdone) state_d = S_ADDR;
      S_ADDR: if (fdone) begin
        case (kind_q)
          K_WRITE: state_d = S_WDATA;
          K_READ:  begin rd_fire = 1'b1; state_d = S_DUMMY; end
          default: state_d = S_STAT;
        endcase
      end
      S_WDATA: if (fdone) begin
        wr_fire   = 1'b1;
        word_done = 1'b1;
        if (last_word) state_d = S_DONE;
      end
      S_DUMMY: if (fdone) begin
        rd_cap  = 1'b1;
        state_d = S_RDATA;
      end
      S_RDATA: begin
        // Prefetch request for the following word on this word's first bit.
        if (cnt == '0 && !last_word) rd_fire = 1'b1;
        if (fdone) begin
          word_done = 1'b1;
          if (last_word) state_d = S_DONE;
          else           rd_cap  = 1'b1;
        end
      end
      S_STAT: if (fdone) begin
        stat_end = 1'b1;
        state_d  = S_DONE;
      end
      default: ;
    endcase
  end

  // Per-frame state: wiped whenever the slave is deselected.
  always_ff @(posedge sclk or negedge frame_rst_n) begin
    if (!frame_rst_n) begin
      state_q <= S_CMD;
      kind_q  <= K_WRITE;
      len_q   <= '0;
      wcnt_q  <= '0;
      addr_q  <= '0;
      tx_q    <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      if (state_q == S_LEN && fdone) len_q <= sr_nxt[LEN_W-1:0];
      if (state_q == S_ADDR && fdone)
        addr_q <= sr_nxt[ADDR_W-1:0] + (rd_fire ? ADDR_INC : '0);
      else if (wr_fire || rd_fire)
        addr_q <= addr_q + ADDR_INC;
      if (word_done) wcnt_q <= wcnt_q + 1'b1;
      if (rd_cap)                  tx_q <= rd_data;
      else if (state_q == S_RDATA) tx_q <= tx_q << 1;
    end
  end

  // Outputs and flag bookkeeping survive deselect; only rstn clears them.
  // An aborted frame cannot be seen at the cs_n edge itself (no sclk then),
  // so open_q remembers whether the last frame stopped outside DONE and the
  // first edge of the next frame raises frame_err.
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      wr_tgl     <= 1'b0;
      wr_adr     <= '0;
      wr_data    <= '0;
      wr_be      <= '0;
      rd_tgl     <= 1'b0;
      rd_adr     <= '0;
      start_flag <= 1'b0;
      open_q     <= 1'b0;
      ferr_set_q <= 1'b0;
      bad_set_q  <= 1'b0;
      stat_end_q <= 1'b0;
    end else begin
      if (wr_fire) begin
        wr_tgl  <= ~wr_tgl;
        wr_adr  <= addr_q;
        wr_data <= sr_nxt[DATA_W-1:0];
        wr_be   <= '1;
      end
      if (rd_fire) begin
        rd_tgl <= ~rd_tgl;
        rd_adr <= (state_q == S_ADDR) ? sr_nxt[ADDR_W-1:0] : addr_q;
      end
      if (do_start) start_flag <= 1'b1;
      if (do_stop)  start_flag <= 1'b0;
      if (!cs_n) open_q <= (state_d != S_DONE);
      ferr_set_q <= !cs_n && open_q && state_q == S_CMD && cnt == '0;
      bad_set_q  <= bad_set;
      stat_end_q <= stat_end;
    end
  end

  assign stat_byte = status_byte(start_flag, frame_err, bad_cmd);
  assign stat_idx  = 3'd7 - cnt[2:0];

  // Falling-edge side: miso launch and sticky flags (set beats clear).
  always_ff @(negedge sclk or negedge rstn) begin
    if (!rstn) begin
      miso      <= 1'b0;
      frame_err <= 1'b0;
      bad_cmd   <= 1'b0;
    end else begin
      frame_err <= ferr_set_q | (frame_err & ~stat_end_q);
      bad_cmd   <= bad_set_q  | (bad_cmd   & ~stat_end_q);
      case (state_q)
        S_RDATA: miso <= tx_q[DATA_W-1];
        S_STAT:  miso <= stat_byte[stat_idx];
        default: miso <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_burst_slave.sv
// Directed self-checking bench for spi_burst_slave with a toggle-driven
// bridge model on the write and read handoffs.
module tb_spi_burst_slave;

  logic        sclk = 1'b0;
  logic        rstn = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso, miso_oe, wr_tgl, rd_tgl, start_flag;
  logic [31:0] wr_adr, wr_data, rd_adr, rd_data;
  logic [3:0]  wr_be;

  int errors = 0;
  int checks = 0;

  always #5 sclk = ~sclk;

  spi_burst_slave #(.ADDR_W(32), .DATA_W(32), .LEN_W(4), .DUMMY_CYC(8)) dut (
    .sclk(sclk), .rstn(rstn), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .miso_oe(miso_oe), .wr_tgl(wr_tgl), .wr_adr(wr_adr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_tgl(rd_tgl), .rd_adr(rd_adr), .rd_data(rd_data),
    .start_flag(start_flag)
  );

  // Bridge model
  logic        wr_seen, rd_seen;
  int          wr_n = 0;
  int          rd_n = 0;
  logic [31:0] wr_adr_log[$];
  logic [31:0] wr_data_log[$];
  logic [31:0] rd_adr_log[$];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a == 32'h40) return 32'hCAFEF00D;
    return {a[15:0], ~a[15:0]};
  endfunction

  always @(negedge sclk) begin
    if (!rstn) begin
      wr_seen = 1'b0;
      rd_seen = 1'b0;
      rd_data = '0;
    end else begin
      if (wr_tgl !== wr_seen) begin
        wr_seen = wr_tgl;
        wr_adr_log.push_back(wr_adr);
        wr_data_log.push_back(wr_data);
        wr_n++;
      end
      if (rd_tgl !== rd_seen) begin
        rd_seen = rd_tgl;
        rd_adr_log.push_back(rd_adr);
        rd_data = mem_rd(rd_adr);
        rd_n++;
      end
    end
  end

  // SPI master helpers; each bit call starts and ends just after a falling edge.
  task automatic xfer(input logic b, output logic m);
    m    = miso;
    mosi = b;
    @(negedge sclk); #1;
  endtask

  task automatic send(input logic [31:0] v, input int n);
    logic m;
    for (int i = n - 1; i >= 0; i--) xfer(v[i], m);
  endtask

  task automatic recv(input int n, output logic [31:0] v);
    logic m;
    v = '0;
    for (int i = 0; i < n; i++) begin
      xfer(1'b0, m);
      v = {v[30:0], m};
    end
  endtask

  task automatic frame_begin();
    @(negedge sclk); #1;
    cs_n = 1'b0;
  endtask

  task automatic frame_end();
    cs_n = 1'b1;
    mosi = 1'b0;
    @(negedge sclk); #1;
  endtask

  task automatic read_status(output logic [7:0] s);
    logic [31:0] v;
    frame_begin();
    send(32'h05, 8); send(32'h0, 4); send(32'h0, 32);
    recv(8, v);
    frame_end();
    s = v[7:0];
  endtask

  task automatic test_reset();
    logic [104:0] o;
    rstn = 1'b0; cs_n = 1'b1;
    repeat (3) @(negedge sclk);
    #1;
    o = {miso, miso_oe, wr_tgl, wr_adr, wr_data, wr_be, rd_tgl, rd_adr, start_flag};
    checks++;
    if (o !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", o); end
    cs_n = 1'b0; #1;
    checks++;
    if (miso_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", miso_oe); end
    cs_n = 1'b1; rstn = 1'b1;
    @(negedge sclk); #1;
    cs_n = 1'b0; #1;
    checks++;
    if (miso_oe !== 1'b1) begin errors++; $display("FAIL oe_selected: got %b want 1", miso_oe); end
    cs_n = 1'b1; #1;
    checks++;
    if (miso_oe !== 1'b0) begin errors++; $display("FAIL oe_deselected: got %b want 0", miso_oe); end
  endtask

  task automatic test_write();
    int base = wr_n;
    frame_begin();
    send(32'h01, 8); send(32'h1, 4); send(32'h100, 32);
    send(32'hDEADBEEF, 32);
    checks++;
    if (wr_n - base !== 1) begin errors++; $display("FAIL wr_first_word: got %0d flips want 1", wr_n - base); end
    send(32'h12345678, 32);
    frame_end();
    checks++;
    if (wr_n - base !== 2) begin errors++; $display("FAIL wr_count: got %0d want 2", wr_n - base); end
    else begin
      checks++;
      if (wr_adr_log[base] !== 32'h100 || wr_data_log[base] !== 32'hDEADBEEF) begin
        errors++; $display("FAIL wr_word0: got %h/%h want 00000100/deadbeef", wr_adr_log[base], wr_data_log[base]);
      end
      checks++;
      if (wr_adr_log[base+1] !== 32'h104 || wr_data_log[base+1] !== 32'h12345678) begin
        errors++; $display("FAIL wr_word1: got %h/%h want 00000104/12345678", wr_adr_log[base+1], wr_data_log[base+1]);
      end
    end
    checks++;
    if (wr_be !== 4'hF) begin errors++; $display("FAIL wr_be: got %h want f", wr_be); end
  endtask

  task automatic test_read();
    int base = rd_n;
    logic [31:0] v;
    frame_begin();
    send(32'h02, 8); send(32'h0, 4); send(32'h40, 32);
    checks++;
    if (rd_n - base !== 1) begin errors++; $display("FAIL rd_at_addr: got %0d flips want 1", rd_n - base); end
    else begin
      checks++;
      if (rd_adr_log[base] !== 32'h40) begin errors++; $display("FAIL rd_adr: got %h want 00000040", rd_adr_log[base]); end
    end
    recv(8, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL rd_dummy_miso: got %h want 0", v); end
    recv(32, v);
    checks++;
    if (v !== 32'hCAFEF00D) begin errors++; $display("FAIL rd_data: got %h want cafef00d", v); end
    recv(8, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL rd_done_miso: got %h want 0", v); end
    frame_end();
    checks++;
    if (rd_n - base !== 1) begin errors++; $display("FAIL rd_single_flip: got %0d want 1", rd_n - base); end
  endtask

  task automatic test_read_burst();
    int base = rd_n;
    logic [31:0] v;
    logic [31:0] exp_d [3];
    logic [31:0] exp_a [3];
    exp_a = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000};
    exp_d = '{32'hFFF80007, 32'hFFFC0003, 32'h0000FFFF};
    frame_begin();
    send(32'h02, 8); send(32'h2, 4); send(32'hFFFFFFF8, 32);
    recv(8, v);
    for (int w = 0; w < 3; w++) begin
      recv(32, v);
      checks++;
      if (v !== exp_d[w]) begin errors++; $display("FAIL burst_data%0d: got %h want %h", w, v, exp_d[w]); end
    end
    frame_end();
    checks++;
    if (rd_n - base !== 3) begin errors++; $display("FAIL burst_flips: got %0d want 3", rd_n - base); end
    else begin
      for (int w = 0; w < 3; w++) begin
        checks++;
        if (rd_adr_log[base+w] !== exp_a[w]) begin
          errors++; $display("FAIL burst_adr%0d: got %h want %h", w, rd_adr_log[base+w], exp_a[w]);
        end
      end
    end
  endtask

  task automatic test_start_stop();
    logic [7:0] s;
    frame_begin(); send(32'h03, 8);
    checks++;
    if (start_flag !== 1'b1) begin errors++; $display("FAIL start_flag_set: got %b want 1", start_flag); end
    frame_end();
    read_status(s);
    checks++;
    if (s !== 8'h04) begin errors++; $display("FAIL status_running: got %h want 04", s); end
    frame_begin(); send(32'h04, 8); frame_end();
    checks++;
    if (start_flag !== 1'b0) begin errors++; $display("FAIL start_flag_clr: got %b want 0", start_flag); end
  endtask

  task automatic test_bad_cmd();
    logic [7:0] s;
    frame_begin(); send(32'h7F, 8); frame_end();
    read_status(s);
    checks++;
    if (s !== 8'h01) begin errors++; $display("FAIL status_bad_cmd: got %h want 01", s); end
    read_status(s);
    checks++;
    if (s !== 8'h00) begin errors++; $display("FAIL status_bad_clr: got %h want 00", s); end
  endtask

  task automatic test_abort();
    logic [7:0] s;
    int base = wr_n;
    frame_begin();
    send(32'h01, 8); send(32'h0, 4); send(32'h200, 32);
    send(32'hABCDE, 20);
    frame_end();
    checks++;
    if (wr_n !== base) begin errors++; $display("FAIL abort_no_wr: got %0d flips want 0", wr_n - base); end
    read_status(s);
    checks++;
    if (s !== 8'h02) begin errors++; $display("FAIL status_frame_err: got %h want 02", s); end
    read_status(s);
    checks++;
    if (s !== 8'h00) begin errors++; $display("FAIL status_ferr_clr: got %h want 00", s); end
  endtask

  task automatic test_rstn_mid_frame();
    logic [104:0] o;
    logic [7:0]   s;
    int base = wr_n;
    frame_begin(); send(32'h03, 8); frame_end();
    frame_begin();
    send(32'h01, 8); send(32'h1, 4); send(32'h300, 32);
    send(32'hA5A5A5A5, 32);
    checks++;
    if (wr_n - base !== 1 || wr_adr_log[base] !== 32'h300 || wr_data_log[base] !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL pre_reset_wr: got %0d flips want 1 at 00000300/a5a5a5a5", wr_n - base);
    end
    send(32'h5, 3);
    rstn = 1'b0; #1;
    o = {miso, miso_oe, wr_tgl, wr_adr, wr_data, wr_be, rd_tgl, rd_adr, start_flag};
    checks++;
    if (o !== '0) begin errors++; $display("FAIL midframe_reset: got %h want 0", o); end
    @(negedge sclk); #1;
    cs_n = 1'b1;
    rstn = 1'b1;
    read_status(s);
    checks++;
    if (s !== 8'h00) begin errors++; $display("FAIL status_after_reset: got %h want 00", s); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_read_burst();
    test_start_stop();
    test_bad_cmd();
    test_abort();
    test_rstn_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
